// File: rtl/cla_seq_ctrl.sv
// Chunk-serial adder controller: reuses one external CHUNK-bit CLA slice, LSB chunk first.
// Optional signed-overflow flag port ovf is enabled with `define CLA_SEQ_OVF_EN.
module cla_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CHUNK-1:0] slice_a,
  output logic [CHUNK-1:0] slice_b,
  output logic             slice_cin,
  input  logic [CHUNK-1:0] slice_sum,
  input  logic             slice_cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
      $error("cla_seq_ctrl: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;
  logic             busy_q;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  // Slice bus is only live while running so the shared slice sees quiet inputs otherwise.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state_q == ST_RUN) begin
      slice_a   = a_q[CHUNK*idx_q +: CHUNK];
      slice_b   = b_q[CHUNK*idx_q +: CHUNK];
      slice_cin = carry_q;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  always_comb begin
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_q[CHUNK*idx_q +: CHUNK] <= slice_sum;
          carry_q                     <= slice_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= slice_cout;
            done_q  <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl: 16/4 instance plus a single-chunk 4/4 instance,
// each fed by a behavioural 4-bit adder slice.
module tb_cla_seq_ctrl;

  logic        clk;
  logic        rst;

  logic        start0, cin0, busy0, done0, cout0;
  logic [15:0] a0, b0, sum0;
  logic [3:0]  sa0, sb0, ss0;
  logic        sc0, sco0;

  logic        start1, cin1, busy1, done1, cout1;
  logic [3:0]  a1, b1, sum1;
  logic [3:0]  sa1, sb1, ss1;
  logic        sc1, sco1;

`ifdef CLA_SEQ_OVF_EN
  logic        ovf0, ovf1;
`endif

  int vec = 0;
  int err = 0;

  assign {sco0, ss0} = {1'b0, sa0} + {1'b0, sb0} + {4'b0, sc0};
  assign {sco1, ss1} = {1'b0, sa1} + {1'b0, sb1} + {4'b0, sc1};

  cla_seq_ctrl #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0),
    .slice_a(sa0), .slice_b(sb0), .slice_cin(sc0),
    .slice_sum(ss0), .slice_cout(sco0)
`ifdef CLA_SEQ_OVF_EN
    , .ovf(ovf0)
`endif
  );

  cla_seq_ctrl #(.WIDTH(4), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .slice_a(sa1), .slice_b(sb1), .slice_cin(sc1),
    .slice_sum(ss1), .slice_cout(sco1)
`ifdef CLA_SEQ_OVF_EN
    , .ovf(ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected finish");
    $fatal(1, "watchdog");
  end

  // Issue one add on the 16-bit instance; returns cycles from accepting edge to done (-1 on timeout).
  task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        output int lat);
    @(negedge clk);
    a0 = av; b0 = bv; cin0 = ci; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (done0) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
    a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1;
    a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({busy0, done0, cout0, sum0} !== 19'd0) begin
      err++; $display("FAIL reset_dut0: got busy=%b done=%b cout=%b sum=%h expected all 0", busy0, done0, cout0, sum0);
    end
    vec++;
    if ({sa0, sb0, sc0} !== 9'd0) begin
      err++; $display("FAIL reset_slice0: got a=%h b=%h cin=%b expected 0", sa0, sb0, sc0);
    end
    vec++;
    if ({busy1, done1, cout1, sum1} !== 7'd0) begin
      err++; $display("FAIL reset_dut1: got busy=%b done=%b cout=%b sum=%h expected all 0", busy1, done1, cout1, sum1);
    end
`ifdef CLA_SEQ_OVF_EN
    vec++;
    if ({ovf0, ovf1} !== 2'b00) begin
      err++; $display("FAIL reset_ovf: got %b%b expected 00", ovf0, ovf1);
    end
`endif
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    @(negedge clk);
    vec++;
    if (busy0 !== 1'b0) begin
      err++; $display("FAIL reset_start_lost: got busy=%b expected 0", busy0);
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start0 = 1'b0; a0 = 16'hDEAD; b0 = 16'hBEEF;
      vec++;
      if (done0 !== (k == 4)) begin
        err++; $display("FAIL basic_done k=%0d: got %b expected %b", k, done0, (k == 4));
      end
      vec++;
      if (busy0 !== (k <= 4)) begin
        err++; $display("FAIL basic_busy k=%0d: got %b expected %b", k, busy0, (k <= 4));
      end
      if (k == 4) begin
        vec++;
        if ({cout0, sum0} !== {1'b0, 16'h5555}) begin
          err++; $display("FAIL basic_sum: got cout=%b sum=%h expected 0 5555", cout0, sum0);
        end
      end
    end
    repeat (3) @(negedge clk);
    vec++;
    if ({busy0, cout0, sum0} !== {1'b0, 1'b0, 16'h5555}) begin
      err++; $display("FAIL basic_hold: got busy=%b cout=%b sum=%h expected 0 0 5555", busy0, cout0, sum0);
    end
    a0 = '0; b0 = '0;
  endtask

  task automatic test_carry;
    int lat;
    do_add(16'h00FF, 16'h0001, 1'b0, lat);
    vec++;
    if (lat !== 4 || {cout0, sum0} !== {1'b0, 16'h0100}) begin
      err++; $display("FAIL carry_ripple: got lat=%0d cout=%b sum=%h expected 4 0 0100", lat, cout0, sum0);
    end
    do_add(16'hFFFF, 16'h0001, 1'b0, lat);
    vec++;
    if (lat !== 4 || {cout0, sum0} !== {1'b1, 16'h0000}) begin
      err++; $display("FAIL carry_wrap: got lat=%0d cout=%b sum=%h expected 4 1 0000", lat, cout0, sum0);
    end
`ifdef CLA_SEQ_OVF_EN
    vec++;
    if (ovf0 !== 1'b0) begin
      err++; $display("FAIL carry_wrap_ovf: got %b expected 0", ovf0);
    end
`endif
  endtask

  task automatic test_ovf_cin;
    int lat;
    do_add(16'h7FFF, 16'h0001, 1'b0, lat);
    vec++;
    if (lat !== 4 || {cout0, sum0} !== {1'b0, 16'h8000}) begin
      err++; $display("FAIL ovf_sum: got lat=%0d cout=%b sum=%h expected 4 0 8000", lat, cout0, sum0);
    end
`ifdef CLA_SEQ_OVF_EN
    vec++;
    if (ovf0 !== 1'b1) begin
      err++; $display("FAIL ovf_set: got %b expected 1", ovf0);
    end
`endif
    do_add(16'h0000, 16'h0000, 1'b1, lat);
    vec++;
    if (lat !== 4 || {cout0, sum0} !== {1'b0, 16'h0001}) begin
      err++; $display("FAIL cin_only: got lat=%0d cout=%b sum=%h expected 4 0 0001", lat, cout0, sum0);
    end
`ifdef CLA_SEQ_OVF_EN
    vec++;
    if (ovf0 !== 1'b0) begin
      err++; $display("FAIL ovf_clear: got %b expected 0", ovf0);
    end
`endif
  endtask

  task automatic test_start_busy;
    int ndone = 0;
    int dk = -1;
    @(negedge clk);
    a0 = 16'h1111; b0 = 16'h1111; cin0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4) begin
        start0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF;
      end else begin
        start0 = 1'b0; a0 = '0; b0 = '0;
      end
      if (done0) begin
        ndone++;
        dk = k;
      end
    end
    vec++;
    if (ndone !== 1 || dk !== 4) begin
      err++; $display("FAIL busy_ignore_done: got count=%0d at k=%0d expected 1 at 4", ndone, dk);
    end
    vec++;
    if ({busy0, sum0} !== {1'b0, 16'h2222}) begin
      err++; $display("FAIL busy_ignore_sum: got busy=%b sum=%h expected 0 2222", busy0, sum0);
    end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    int lat;
    @(negedge clk);
    a0 = 16'hABCD; b0 = 16'h1111; cin0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({busy0, done0, sum0} !== 18'd0) begin
      err++; $display("FAIL reset_mid: got busy=%b done=%b sum=%h expected 0 0 0000", busy0, done0, sum0);
    end
    for (int k = 0; k < 6; k++) begin
      if (done0) ndone++;
      @(negedge clk);
    end
    vec++;
    if (ndone !== 0) begin
      err++; $display("FAIL reset_mid_nodone: got %0d done pulses expected 0", ndone);
    end
    do_add(16'h0001, 16'h0002, 1'b0, lat);
    vec++;
    if (lat !== 4 || {cout0, sum0} !== {1'b0, 16'h0003}) begin
      err++; $display("FAIL reset_recover: got lat=%0d cout=%b sum=%h expected 4 0 0003", lat, cout0, sum0);
    end
  endtask

  task automatic test_slice_bus;
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    logic [2:0] exp_c [4];
    exp_a = '{4'hD, 4'hC, 4'hB, 4'hA};
    exp_b = '{4'h4, 4'h3, 4'h2, 4'h1};
    // Carries into each chunk for 0xABCD + 0x1234 + 1: D+4+1=0x12, C+3+1=0x10, B+2+1=0xE, A+1=0xB.
    exp_c = '{3'd1, 3'd1, 3'd1, 3'd0};
    @(negedge clk);
    vec++;
    if ({sa0, sb0, sc0} !== 9'd0) begin
      err++; $display("FAIL slice_idle: got a=%h b=%h cin=%b expected 0", sa0, sb0, sc0);
    end
    a0 = 16'hABCD; b0 = 16'h1234; cin0 = 1'b1; start0 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start0 = 1'b0; a0 = 16'h5A5A; b0 = 16'hA5A5; cin0 = 1'b0;
      if (k < 4) begin
        vec++;
        if ({sa0, sb0, sc0} !== {exp_a[k], exp_b[k], exp_c[k][0]}) begin
          err++; $display("FAIL slice_run k=%0d: got a=%h b=%h cin=%b expected %h %h %b", k, sa0, sb0, sc0, exp_a[k], exp_b[k], exp_c[k][0]);
        end
      end else begin
        vec++;
        if ({sa0, sb0, sc0} !== 9'd0 || done0 !== 1'b1) begin
          err++; $display("FAIL slice_done: got a=%h b=%h cin=%b done=%b expected 0 0 0 1", sa0, sb0, sc0, done0);
        end
        vec++;
        if ({cout0, sum0} !== {1'b0, 16'hBE02}) begin
          err++; $display("FAIL slice_sum: got cout=%b sum=%h expected 0 be02", cout0, sum0);
        end
      end
    end
    a0 = '0; b0 = '0;
  endtask

  task automatic test_nchunk1;
    @(negedge clk);
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; a1 = '0; b1 = '0;
    vec++;
    if ({busy1, done1, sa1, sb1, sc1} !== {1'b1, 1'b0, 4'hF, 4'h1, 1'b0}) begin
      err++; $display("FAIL n1_run: got busy=%b done=%b a=%h b=%h cin=%b expected 1 0 f 1 0", busy1, done1, sa1, sb1, sc1);
    end
    @(negedge clk);
    vec++;
    if ({done1, cout1, sum1} !== {1'b1, 1'b1, 4'h0}) begin
      err++; $display("FAIL n1_done: got done=%b cout=%b sum=%h expected 1 1 0", done1, cout1, sum1);
    end
`ifdef CLA_SEQ_OVF_EN
    vec++;
    if (ovf1 !== 1'b0) begin
      err++; $display("FAIL n1_ovf: got %b expected 0", ovf1);
    end
`endif
    @(negedge clk);
    vec++;
    if ({busy1, done1} !== 2'b00) begin
      err++; $display("FAIL n1_idle: got busy=%b done=%b expected 0 0", busy1, done1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ovf_cin();
    test_start_busy();
    test_reset_mid();
    test_slice_bus();
    test_nchunk1();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/cla_seq_ctrl.md
Name: cla_seq_ctrl

Overview:
Multi-cycle sequencer that computes a WIDTH-bit add using one external CHUNK-bit carry-lookahead slice. The slice is reused once per chunk, LSB chunk first, with the carry kept in a register between passes. It sits between a requester (start/done handshake) and the shared combinational CLA slice. It owns all operand, sum and carry registers.

Parameters:
WIDTH, 16, operand and sum width; must be an integer multiple of CHUNK.
CHUNK, 4, width of the external CLA slice.
NCHUNK, WIDTH/CHUNK (derived localparam), number of slice passes; minimum 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request pulse; sampled only in IDLE.
a  input  WIDTH  operand A; captured on an accepted start.
b  input  WIDTH  operand B; captured on an accepted start.
cin  input  1  carry-in; captured on an accepted start.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle completion pulse.
sum  output  WIDTH  result register; holds its value until the next accepted start.
cout  output  1  final carry-out register; holds like sum.
slice_a  output  CHUNK  current A chunk sent to the CLA slice.
slice_b  output  CHUNK  current B chunk sent to the CLA slice.
slice_cin  output  1  current carry sent to the CLA slice.
slice_sum  input  CHUNK  sum returned by the CLA slice (combinational).
slice_cout  input  1  carry returned by the CLA slice (combinational).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset has priority over every other input. On rst, at the next edge:
  - state goes to IDLE; idx, carry_reg, a_reg, b_reg all clear to 0.
  - sum, cout, done and busy all clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E: capture a_reg=a, b_reg=b, carry_reg=cin; set idx=0; go to RUN; clear sum and cout to 0.
  - start=0: stay in IDLE.
- RUN (combinational outputs):
  - slice_a = a_reg[idx*CHUNK +: CHUNK]; slice_b = b_reg[idx*CHUNK +: CHUNK]; slice_cin = carry_reg.
- RUN (each edge):
  - sum[idx*CHUNK +: CHUNK] <= slice_sum; carry_reg <= slice_cout.
  - If idx == NCHUNK-1: cout <= slice_cout, go to DONE. Otherwise idx <= idx+1.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
- Timing:
  - Start sampled at edge E; done is high from edge E+NCHUNK to edge E+NCHUNK+1.
  - Latency is 4 cycles at the defaults.
  - Throughput is one add per NCHUNK+2 cycles.
- slice_a, slice_b and slice_cin are driven 0 in IDLE and DONE.
- start in RUN or DONE is ignored and not queued.
- a, b and cin may change freely after the accepting edge; only the registered copies are used.
- NCHUNK=1: a single RUN cycle, then DONE.
- idx width is max(1, $clog2(NCHUNK)); idx never exceeds NCHUNK-1.
- Reset mid-RUN aborts the add: no done pulse, sum=0, state IDLE.
- Reset in the same cycle as start: reset wins and the start is lost.

Optional Feature:
Macro: CLA_SEQ_OVF_EN.
- Defined:
  - Adds port ovf (output, 1): signed two's-complement overflow flag.
  - Updated at the final RUN edge: ovf <= (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (slice_sum[CHUNK-1] != a_reg[WIDTH-1]).
  - Valid with done; holds until the next accepted start, which clears it.
  - Reset clears it to 0.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
Bench supplies a behavioural 4-bit adder as the slice; defaults WIDTH=16, CHUNK=4.
1. Basic add and latency: reset 2 cycles, then a=0x1234, b=0x4321, cin=0, start at edge E -> done only at E+4 for one cycle; sum=0x5555, cout=0; busy high E..E+5; values hold afterwards.
2. Carry ripple and wrap: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0. Then a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1; with CLA_SEQ_OVF_EN, ovf=0.
3. Signed overflow and cin (CLA_SEQ_OVF_EN defined): a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x0000, b=0x0000, cin=1 -> sum=0x0001, ovf=0.
4. Start while busy: start a=0x1111, b=0x1111; pulse start again with a=0xFFFF at E+2 -> ignored; done once at E+4 with sum=0x2222, and no second done.
5. Reset mid-operation: start a=0xABCD, b=0x1111; assert rst at E+2 -> IDLE next edge, busy=0, sum=0, no done. A fresh start then completes normally: 0x0001+0x0002=0x0003.
6. Slice bus checks: slice_a and slice_b show chunk idx of a_reg/b_reg in RUN cycles 0..3, in order; all slice outputs are 0 in IDLE/DONE. Also run NCHUNK=1 (WIDTH=4, CHUNK=4): 0xF+0x1 -> sum=0x0, cout=1, done at E+1.
